// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator: each channel plays an exact-duty
// square wave of a programmed half-period, either continuously or for N periods.
module tone_gen_multi #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 16,
   parameter int CNT_W  = 16,
   parameter int CH_W   = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_half,
   input  logic [CNT_W-1:0]  cfg_cycles,
   input  logic              mute,
   output logic [NUM_CH-1:0] spk,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done,
   output logic              cfg_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   ch_state_e         state_q  [NUM_CH];
   ch_state_e         state_d  [NUM_CH];
   logic [DIV_W-1:0]  half_q   [NUM_CH];
   logic [DIV_W-1:0]  half_d   [NUM_CH];
   logic [CNT_W-1:0]  target_q [NUM_CH];
   logic [CNT_W-1:0]  target_d [NUM_CH];
   logic [DIV_W-1:0]  cnt_q    [NUM_CH];
   logic [DIV_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  per_q    [NUM_CH];
   logic [CNT_W-1:0]  per_d    [NUM_CH];

   logic [NUM_CH-1:0] lvl_q;
   logic [NUM_CH-1:0] lvl_d;
   logic [NUM_CH-1:0] spk_q;
   logic [NUM_CH-1:0] spk_d;
   logic [NUM_CH-1:0] busy_q;
   logic [NUM_CH-1:0] busy_d;
   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] done_d;
   logic              ready_q;
   logic              err_q;
   logic              err_d;

   logic              accept_s;
   logic              ch_ok_s;
   logic [NUM_CH-1:0] hit_s;

   // Extra bit keeps the range check meaningful even when NUM_CH == 2**CH_W.
   assign accept_s = cfg_valid & ready_q;
   assign ch_ok_s  = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
   assign err_d    = accept_s & ~ch_ok_s;

   // Decode which channel an accepted command addresses.
   always_comb begin
      hit_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit_s[i] = accept_s & ch_ok_s & (cfg_ch == CH_W'(i));
      end
   end

   // Per-channel next state: a command always overrides the running wave.
   always_comb begin
      lvl_d  = lvl_q;
      spk_d  = '0;
      busy_d = '0;
      done_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]  = state_q[i];
         half_d[i]   = half_q[i];
         target_d[i] = target_q[i];
         cnt_d[i]    = cnt_q[i];
         per_d[i]    = per_q[i];

         if (hit_s[i]) begin
            cnt_d[i] = '0;
            per_d[i] = '0;
            lvl_d[i] = 1'b0;
            if (cfg_half != '0) begin
               state_d[i]  = ST_RUN;
               half_d[i]   = cfg_half;
               target_d[i] = cfg_cycles;
            end else begin
               state_d[i]  = ST_IDLE;
            end
         end else begin
            case (state_q[i])
               ST_RUN: begin
                  if (cnt_q[i] == half_q[i] - DIV_W'(1)) begin
                     cnt_d[i] = '0;
                     lvl_d[i] = ~lvl_q[i];
                     // A falling edge closes one full period.
                     if (lvl_q[i]) begin
                        per_d[i] = per_q[i] + CNT_W'(1);
                        if ((target_q[i] != '0) &&
                            (per_q[i] + CNT_W'(1) == target_q[i])) begin
                           state_d[i] = ST_IDLE;
                           lvl_d[i]   = 1'b0;
                           done_d[i]  = 1'b1;
                        end else begin
                           state_d[i] = ST_RUN;
                        end
                     end else begin
                        per_d[i] = per_q[i];
                     end
                  end else begin
                     cnt_d[i] = cnt_q[i] + DIV_W'(1);
                  end
               end
               ST_IDLE: begin
                  lvl_d[i] = 1'b0;
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  lvl_d[i]   = 1'b0;
               end
            endcase
         end

         busy_d[i] = (state_d[i] == ST_RUN);
         spk_d[i]  = lvl_d[i] & ~mute;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         lvl_q   <= '0;
         spk_q   <= '0;
         busy_q  <= '0;
         done_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= ST_IDLE;
            half_q[i]   <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= '0;
            per_q[i]    <= '0;
         end
      end else begin
         ready_q  <= 1'b1;
         err_q    <= err_d;
         lvl_q    <= lvl_d;
         spk_q    <= spk_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         state_q  <= state_d;
         half_q   <= half_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         per_q    <= per_d;
      end
   end

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;
   assign spk       = spk_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_tone_gen_multi.sv
// Bench for tone_gen_multi: closed-form timing model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_tone_gen_multi;

   localparam int NUM_CH = 2;
   localparam int DIV_W  = 16;
   localparam int CNT_W  = 16;
   localparam int CH_W   = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_half;
   logic [CNT_W-1:0]  cfg_cycles;
   logic              mute;
   logic [NUM_CH-1:0] spk;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] done;
   logic              cfg_err;

   int n_checks = 0;
   int n_fail   = 0;

   tone_gen_multi #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W), .CH_W(CH_W)
   ) dut (
      .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_cycles(cfg_cycles), .mute(mute),
      .spk(spk), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // Model state: edge count, and per channel the edge a wave started on.
   int   cyc = 0;
   logic ready_m = 1'b0;
   logic err_m = 1'b0;
   logic mute_m = 1'b0;
   logic act_m [NUM_CH];
   int   start_m [NUM_CH];
   int   half_m [NUM_CH];
   int   n_m [NUM_CH];

   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         act_m[i] = 1'b0; start_m[i] = 0; half_m[i] = 0; n_m[i] = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      mute_m  <= mute;
      ready_m <= resetn;
      err_m   <= resetn && cfg_valid && ready_m && (int'(cfg_ch) >= NUM_CH);
      for (int i = 0; i < NUM_CH; i++) begin
         if (!resetn) begin
            act_m[i] <= 1'b0;
         end else if (cfg_valid && ready_m && int'(cfg_ch) == i) begin
            act_m[i]   <= (cfg_half != '0);
            start_m[i] <= cyc + 1;
            half_m[i]  <= int'(cfg_half);
            n_m[i]     <= int'(cfg_cycles);
         end
      end
   end

   // Compare every output against the model once per cycle.
   always @(negedge clk) begin
      logic [NUM_CH-1:0] s_e, b_e, d_e;
      longint e, len;
      if (cyc > 0) begin
         s_e = '0; b_e = '0; d_e = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (act_m[i] && half_m[i] != 0) begin
               e   = longint'(cyc - start_m[i]);
               len = 2 * longint'(n_m[i]) * longint'(half_m[i]);
               b_e[i] = !(n_m[i] != 0 && e >= len);
               d_e[i] = (n_m[i] != 0 && e == len);
               s_e[i] = b_e[i] && ((e / half_m[i]) % 2 == 1) && !mute_m;
            end
         end
         check("model_spk", 32'(spk), 32'(s_e));
         check("model_busy", 32'(busy), 32'(b_e));
         check("model_done", 32'(done), 32'(d_e));
         check("model_err", 32'(cfg_err), 32'(err_m));
         check("model_ready", 32'(cfg_ready), 32'(ready_m));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int ch, input int h, input int c);
      cfg_valid  = 1'b1;
      cfg_ch     = CH_W'(ch);
      cfg_half   = DIV_W'(h);
      cfg_cycles = CNT_W'(c);
      @(negedge clk);
      cfg_valid  = 1'b0;
   endtask

   initial begin
      logic [12:0] pat;
      pat = 13'b0111000111000;
      resetn = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
      cfg_cycles = '0; mute = 1'b0;

      // Reset, then release
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ready", 32'(cfg_ready), 32'd0);
         check("rst_spk", 32'(spk), 32'd0);
      end
      resetn = 1'b1;
      tick(1);
      check("ready_after_rst", 32'(cfg_ready), 32'd1);

      // Finite burst: half=3, 2 periods
      send(0, 3, 2);
      for (int j = 0; j <= 12; j++) begin
         check("burst_spk", 32'(spk[0]), 32'(pat[j]));
         check("burst_done", 32'(done[0]), (j == 12) ? 32'd1 : 32'd0);
         check("burst_busy", 32'(busy[0]), (j == 12) ? 32'd0 : 32'd1);
         tick(1);
      end
      tick(3);

      // Continuous ch1 half=4, retrigger mid-high with half=2
      send(1, 4, 0);
      tick(5);
      check("cont_high", 32'(spk[1]), 32'd1);
      send(1, 2, 0);
      check("retrig_low", 32'(spk[1]), 32'd0);
      tick(2);
      check("retrig_high", 32'(spk[1]), 32'd1);
      tick(14);

      // Continuous ch0 half=5 with mute pulse, then stop both channels
      send(0, 5, 0);
      tick(12);
      mute = 1'b1;
      for (int j = 0; j < 7; j++) begin
         tick(1);
         check("muted_spk", 32'(spk), 32'd0);
      end
      mute = 1'b0;
      tick(20);
      send(0, 0, 0);
      check("stop_busy", 32'(busy[0]), 32'd0);
      check("stop_spk", 32'(spk[0]), 32'd0);
      send(1, 0, 0);
      check("stop1_busy", 32'(busy), 32'd0);
      tick(3);

      // half=1 burst of 3 periods
      send(1, 1, 3);
      check("h1_spk0", 32'(spk[1]), 32'd0);
      tick(1);
      check("h1_spk1", 32'(spk[1]), 32'd1);
      tick(5);
      check("h1_done", 32'(done[1]), 32'd1);
      tick(2);

      // Command collides with burst end
      send(0, 2, 1);
      tick(3);
      send(0, 2, 1);
      check("coll_done", 32'(done[0]), 32'd0);
      check("coll_busy", 32'(busy[0]), 32'd1);
      tick(3);
      check("coll_spk", 32'(spk[0]), 32'd1);
      tick(1);
      check("coll_end_done", 32'(done[0]), 32'd1);
      check("coll_end_busy", 32'(busy[0]), 32'd0);

      // Out-of-range channel
      send(NUM_CH, 3, 1);
      check("err_pulse", 32'(cfg_err), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      tick(1);
      check("err_clear", 32'(cfg_err), 32'd0);

      // Reset during period 2 of a 5-period burst
      send(0, 3, 5);
      tick(7);
      resetn = 1'b0;
      tick(1);
      check("mid_rst_spk", 32'(spk), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      tick(1);
      resetn = 1'b1;
      tick(12);
      check("post_rst_busy", 32'(busy), 32'd0);
      send(0, 3, 1);
      check("restart_busy", 32'(busy[0]), 32'd1);
      tick(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
